// File: rtl/otter_pkg.sv
// Shared Otter MCU definitions: datapath widths and the write-back source select.
package otter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    CSR      = 2'b01,
    MEM      = 2'b10,
    ALU      = 2'b11
  } rf_wr_sel_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register that is set when a load issues
// and cleared by its write-back; a set on the same edge as a clear wins.
module rf_scoreboard #(
  parameter int NREGS = otter_pkg::NREGS
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     pend_set,
  input  logic [$clog2(NREGS)-1:0] pend_addr,
  input  logic                     rf_we,
  input  logic [$clog2(NREGS)-1:0] wa,
  output logic [NREGS-1:0]         pend,
  output logic                     pend_any
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] pend_nxt;

  always_comb begin
    // NOTE: default assignment first so every path drives pend_nxt and no latch is inferred.
    pend_nxt = pend;
    for (int i = 1; i < NREGS; i++) begin
      if (rf_we && wa == AW'(i))
        pend_nxt[i] = 1'b0;
      // Evaluated after the clear so a re-issued load to the same register wins.
      if (pend_set && pend_addr == AW'(i))
        pend_nxt[i] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RST_N) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign pend_any = |pend;

endmodule

// File: rtl/otter_reg_file.sv
// Otter RV32I integer register file: x0 hardwired to zero, one synchronous write
// port, two combinational read ports. Define RF_BYPASS_EN for write-through forwarding.
module otter_reg_file #(
  parameter int XLEN  = otter_pkg::XLEN,
  parameter int NREGS = otter_pkg::NREGS
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     rf_we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [XLEN-1:0]          wd,
  input  logic [$clog2(NREGS)-1:0] adr1,
  input  logic [$clog2(NREGS)-1:0] adr2,
  output logic [XLEN-1:0]          rs1,
  output logic [XLEN-1:0]          rs2,
  input  logic                     pend_set,
  input  logic [$clog2(NREGS)-1:0] pend_addr,
  output logic                     rs1_pend,
  output logic                     rs2_pend,
  output logic                     pend_any
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;

  rf_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rf_we     (rf_we),
    .wa        (wa),
    .pend      (pend),
    .pend_any  (pend_any)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: the architectural state must clear on reset, so this array is built from
    // resettable flops rather than an SRAM macro.
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

`ifdef RF_BYPASS_EN
  // Forwarding is gated by reset so outputs stay zero while reset is held.
  logic byp1, byp2;
  assign byp1 = RST_N && rf_we && (wa != '0) && (adr1 == wa);
  assign byp2 = RST_N && rf_we && (wa != '0) && (adr2 == wa);
`endif

  always_comb begin
    rs1      = (adr1 == '0) ? '0 : regs[adr1];
    rs2      = (adr2 == '0) ? '0 : regs[adr2];
    rs1_pend = pend[adr1];
    rs2_pend = pend[adr2];
`ifdef RF_BYPASS_EN
    if (byp1) begin
      rs1      = wd;
      rs1_pend = 1'b0;
    end
    if (byp2) begin
      rs2      = wd;
      rs2_pend = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_otter_reg_file.sv
// Directed self-checking bench for otter_reg_file; expectations follow RF_BYPASS_EN.
module tb_otter_reg_file;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            rf_we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;
  logic [4:0]      adr1, adr2;
  logic [XLEN-1:0] rs1, rs2;
  logic            pend_set;
  logic [4:0]      pend_addr;
  logic            rs1_pend, rs2_pend, pend_any;

  int errors = 0;
  int checks = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  otter_reg_file dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rf_we     (rf_we),
    .wa        (wa),
    .wd        (wd),
    .adr1      (adr1),
    .adr2      (adr2),
    .rs1       (rs1),
    .rs2       (rs2),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .pend_any  (pend_any)
  );

  always #5 CLK = ~CLK;

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    rf_we = 1'b0; wa = '0; wd = '0; pend_set = 1'b0; pend_addr = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; idle(); adr1 = 5'd0; adr2 = 5'd31;
    #12;
    checks++; if (rs1 !== 32'h0) begin errors++; $display("FAIL reset_rs1: got %h want 0", rs1); end
    checks++; if (rs2 !== 32'h0) begin errors++; $display("FAIL reset_rs2: got %h want 0", rs2); end
    checks++; if ({rs1_pend, rs2_pend, pend_any} !== 3'b000) begin
      errors++; $display("FAIL reset_pend: got %b want 000", {rs1_pend, rs2_pend, pend_any});
    end
    @(negedge CLK); RST_N = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    rf_we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; adr1 = 5'd5; adr2 = 5'd0;
    #1;
    checks++; if (rs1 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      errors++; $display("FAIL wr_same_cycle: got %h want %h", rs1, BYP ? 32'hDEADBEEF : 32'h0);
    end
    tick(); idle();
    #1;
    checks++; if (rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5: got %h want deadbeef", rs1); end
    checks++; if (rs2 !== 32'h0) begin errors++; $display("FAIL rd_x0: got %h want 0", rs2); end
    // Boundary register x31.
    rf_we = 1'b1; wa = 5'd31; wd = 32'hCAFE0031;
    tick(); idle(); adr2 = 5'd31;
    #1;
    checks++; if (rs2 !== 32'hCAFE0031) begin errors++; $display("FAIL wr_x31: got %h want cafe0031", rs2); end
  endtask

  task automatic test_x0();
    rf_we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; adr1 = 5'd0;
    #1;
    checks++; if (rs1 !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rs1); end
    tick(); idle();
    #1;
    checks++; if (rs1 !== 32'h0) begin errors++; $display("FAIL x0_write: got %h want 0", rs1); end
    pend_set = 1'b1; pend_addr = 5'd0;
    tick(); idle();
    #1;
    checks++; if (rs1_pend !== 1'b0) begin errors++; $display("FAIL x0_pend: got %b want 0", rs1_pend); end
    checks++; if (pend_any !== 1'b0) begin errors++; $display("FAIL x0_pend_any: got %b want 0", pend_any); end
  endtask

  task automatic test_same_cycle();
    rf_we = 1'b1; wa = 5'd7; wd = 32'h11;
    tick();
    wd = 32'h22; adr1 = 5'd7;
    #1;
    checks++; if (rs1 !== (BYP ? 32'h22 : 32'h11)) begin
      errors++; $display("FAIL same_cycle_rd: got %h want %h", rs1, BYP ? 32'h22 : 32'h11);
    end
    tick(); idle();
    #1;
    checks++; if (rs1 !== 32'h22) begin errors++; $display("FAIL next_cycle_rd: got %h want 22", rs1); end
  endtask

  task automatic test_pending();
    pend_set = 1'b1; pend_addr = 5'd3; adr2 = 5'd3;
    #1;
    checks++; if (rs2_pend !== 1'b0) begin errors++; $display("FAIL pend_early: got %b want 0", rs2_pend); end
    tick(); idle();
    #1;
    checks++; if (rs2_pend !== 1'b1) begin errors++; $display("FAIL pend_set_x3: got %b want 1", rs2_pend); end
    checks++; if (pend_any !== 1'b1) begin errors++; $display("FAIL pend_any_x3: got %b want 1", pend_any); end
    rf_we = 1'b1; wa = 5'd3; wd = 32'h5;
    #1;
    checks++; if (rs2_pend !== !BYP) begin errors++; $display("FAIL pend_wb_cycle: got %b want %b", rs2_pend, !BYP); end
    checks++; if (rs2 !== (BYP ? 32'h5 : 32'h0)) begin
      errors++; $display("FAIL rs2_wb_cycle: got %h want %h", rs2, BYP ? 32'h5 : 32'h0);
    end
    tick(); idle();
    #1;
    checks++; if (rs2_pend !== 1'b0) begin errors++; $display("FAIL pend_clear_x3: got %b want 0", rs2_pend); end
    checks++; if (pend_any !== 1'b0) begin errors++; $display("FAIL pend_any_clear: got %b want 0", pend_any); end
    checks++; if (rs2 !== 32'h5) begin errors++; $display("FAIL rd_x3: got %h want 5", rs2); end
  endtask

  task automatic test_set_clear_same_edge();
    pend_set = 1'b1; pend_addr = 5'd9; rf_we = 1'b1; wa = 5'd9; wd = 32'h0ABC; adr1 = 5'd9;
    tick(); idle();
    #1;
    checks++; if (rs1 !== 32'h0ABC) begin errors++; $display("FAIL set_clr_data: got %h want abc", rs1); end
    checks++; if (rs1_pend !== 1'b1) begin errors++; $display("FAIL set_clr_pend: got %b want 1", rs1_pend); end
    // A pend on one register must not show on another address.
    adr2 = 5'd8;
    #1;
    checks++; if (rs2_pend !== 1'b0) begin errors++; $display("FAIL pend_other: got %b want 0", rs2_pend); end
    rf_we = 1'b1; wa = 5'd9; wd = 32'h0DEF;
    tick(); idle();
    #1;
    checks++; if ({rs1_pend, pend_any} !== 2'b00) begin
      errors++; $display("FAIL x9_clear: got %b want 00", {rs1_pend, pend_any});
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      rf_we = 1'b1; wa = 5'(i); wd = 32'h1000 + i;
      tick();
    end
    idle(); pend_set = 1'b1; pend_addr = 5'd4;
    tick(); idle();
    adr1 = 5'd17; adr2 = 5'd4;
    #1;
    checks++; if (rs1 !== 32'h1011) begin errors++; $display("FAIL fill_x17: got %h want 1011", rs1); end
    checks++; if ({rs2, rs2_pend} !== {32'h1004, 1'b1}) begin
      errors++; $display("FAIL fill_x4: got %h/%b want 1004/1", rs2, rs2_pend);
    end
    // Reset mid-cycle with a write to x12 in flight.
    rf_we = 1'b1; wa = 5'd12; wd = 32'h77777777; adr1 = 5'd12;
    #1; RST_N = 1'b0;
    #1;
    checks++; if ({rs1_pend, rs2_pend, pend_any} !== 3'b000) begin
      errors++; $display("FAIL areset_pend: got %b want 000", {rs1_pend, rs2_pend, pend_any});
    end
    checks++; if (rs1 !== 32'h0) begin errors++; $display("FAIL areset_x12: got %h want 0", rs1); end
    for (int i = 0; i < 32; i++) begin
      adr1 = 5'(i); adr2 = 5'(31 - i);
      #1;
      checks++; if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
        errors++; $display("FAIL areset_rd[%0d]: got %h/%h want 0/0", i, rs1, rs2);
      end
    end
    @(posedge CLK);
    idle();
    @(negedge CLK); RST_N = 1'b1;
    adr1 = 5'd12; adr2 = 5'd31;
    #1;
    checks++; if (rs1 !== 32'h0) begin errors++; $display("FAIL lost_write_x12: got %h want 0", rs1); end
    checks++; if (rs2 !== 32'h0) begin errors++; $display("FAIL post_reset_x31: got %h want 0", rs2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_same_cycle();
    test_pending();
    test_set_clear_same_edge();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
